pipe_hazard_ctrl: RTL

- Parametrised successor to the fixed hazard-detection and forwarding logic of the 5-stage ARM pipeline.
- Merges three functions into one block:
  - RAW hazard detection, with a runtime mode: 0 = stall-only, 1 = forwarding.
  - Forwarding-select generation for EXE.
  - A variable-latency data-memory wait FSM that freezes the whole pipeline.
- Adds branch-flush arbitration, a memory-timeout error flag and saturating performance counters.
- Sits beside the stage registers and drives their freeze, flush and bubble controls.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard / forwarding / memory-wait controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic MODE_STALL = 1'b0;
  localparam logic MODE_FWD   = 1'b1;

  // MEM result is younger than WB, so it wins when both match
  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, EXE forwarding select, data-memory wait FSM and perf counters
// for the 5-stage pipeline; drives freeze/flush/bubble of the stage registers.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] exe_src1,
  input  logic [REG_AW-1:0] exe_src2,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              freeze_front,
  output logic              bubble_exe,
  output logic              flush,
  output logic              stall_all,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  wait_cnt_total
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic              w_stall_all;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_err;

  logic w_s1_exe, w_s1_mem, w_s2_exe, w_s2_mem;
  logic w_haz;
  fwd_sel_t w_sel1, w_sel2;

  // Memory-wait state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and the whole-pipeline stall; a same-cycle ready costs nothing
  always_comb begin
    w_next_state = r_state;
    w_stall_all  = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          w_next_state = MEM_WAIT;
          w_stall_all  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_next_state = RUN;
        end else begin
          w_stall_all = 1'b1;
        end
      end
      default: w_next_state = RUN;
    endcase
    if (rst) begin
      w_stall_all = 1'b0;
    end
  end

  // Consecutive-wait counter; error latches when the count reaches the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else if (w_stall_all) begin
      if (r_wait_cnt != WCNT_W'(MEM_TIMEOUT)) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
      if (r_wait_cnt >= WCNT_W'(MEM_TIMEOUT - 1)) begin
        r_mem_err <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_s1_exe = exe_wb_en && (id_src1 == exe_dest);
  assign w_s1_mem = mem_wb_en && (id_src1 == mem_dest);
  assign w_s2_exe = id_two_src && exe_wb_en && (id_src2 == exe_dest);
  assign w_s2_mem = id_two_src && mem_wb_en && (id_src2 == mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time
  always_comb begin
    w_haz = 1'b0;
    if (mode == MODE_FWD) begin
      w_haz = exe_mem_r_en && (w_s1_exe || w_s2_exe);
    end else begin
      w_haz = w_s1_exe || w_s1_mem || w_s2_exe || w_s2_mem;
    end
  end

  // Stage-register controls: memory stall, then branch flush, then hazard bubble
  always_comb begin
    freeze_front = 1'b0;
    bubble_exe   = 1'b0;
    flush        = 1'b0;
    if (!rst && !w_stall_all) begin
      if (branch_taken) begin
        flush = 1'b1;
      end else if (w_haz) begin
        freeze_front = 1'b1;
        bubble_exe   = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel1 = FWD_REG;
    w_sel2 = FWD_REG;
    if (!rst && (mode == MODE_FWD)) begin
      w_sel1 = fwd_pick(mem_wb_en && (exe_src1 == mem_dest), wb_wb_en && (exe_src1 == wb_dest));
      w_sel2 = fwd_pick(mem_wb_en && (exe_src2 == mem_dest), wb_wb_en && (exe_src2 == wb_dest));
    end
  end

  assign sel_src1  = w_sel1;
  assign sel_src2  = w_sel2;
  assign stall_all = w_stall_all;
  assign mem_err   = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_front),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_all),
    .count (wait_cnt_total)
  );

endmodule
